// File: rtl/color_manager_cfg_pkg.sv
// Shared constants, field widths, reset codes and FSM encoding for the
// Color Manager configuration responder.
package color_manager_cfg_pkg;

    localparam logic [3:0] CM_ADDR_UART_BOUDRATE = 4'h8;
    localparam logic [3:0] CM_ADDR_UART_PARITY   = 4'h9;
    localparam logic [3:0] CM_ADDR_UART_STOP     = 4'hA;
    localparam logic [3:0] CM_ADDR_VGA_CONFIG    = 4'hB;
    localparam logic [3:0] CM_ADDR_VGA_QUADRAN   = 4'hC;
    localparam logic [3:0] CM_ADDR_VGA_COLOR     = 4'h0;

    localparam int BAUD_W   = 3;
    localparam int PARITY_W = 2;
    localparam int STOP_W   = 1;
    localparam int RES_W    = 2;
    localparam int QUAD_W   = 2;

    localparam logic [BAUD_W-1:0]   CM_RST_BAUD   = 3'd2;
    localparam logic [PARITY_W-1:0] CM_RST_PARITY = 2'd0;
    localparam logic [RES_W-1:0]    CM_RST_RES    = 2'd0;

    typedef struct packed {
        logic [BAUD_W-1:0]   baud;
        logic [PARITY_W-1:0] parity;
        logic [STOP_W-1:0]   stop;
    } uart_cfg_t;

    typedef struct packed {
        logic [RES_W-1:0]  res;
        logic [QUAD_W-1:0] quad;
    } vga_cfg_t;

    localparam int UART_CFG_W = $bits(uart_cfg_t);
    localparam int VGA_CFG_W  = $bits(vga_cfg_t);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DECODE    = 2'd1,
        ST_WAIT_UART = 2'd2,
        ST_WAIT_VGA  = 2'd3
    } cm_state_t;

endpackage

// File: rtl/color_manager_cfg_shadow.sv
// Shadow/live register pair: load stages a value, commit makes it live.
// Load and commit in the same cycle pass the loaded value straight through.
module color_manager_cfg_shadow
    import color_manager_cfg_pkg::*;
#(
    parameter int             W       = 4,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         load_i,
    input  logic [W-1:0] load_data_i,
    input  logic         commit_i,
    output logic [W-1:0] live_o
);

    logic [W-1:0] shadow_q, shadow_d;
    logic [W-1:0] live_q, live_d;

    always_comb begin
        shadow_d = shadow_q;
        live_d   = live_q;
        if (load_i) begin
            shadow_d = load_data_i;
        end
        if (commit_i) begin
            live_d = load_i ? load_data_i : shadow_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            shadow_q <= RST_VAL;
            live_q   <= RST_VAL;
        end else begin
            shadow_q <= shadow_d;
            live_q   <= live_d;
        end
    end

    assign live_o = live_q;

endmodule

// File: rtl/color_manager_config_responder.sv
// Configuration-bus responder for the Color Manager UART/VGA settings.
// Optional macro CM_CFG_FRAME_SYNC_EN: hold VGA commits until VGA_Frame_End.
module color_manager_config_responder
    import color_manager_cfg_pkg::*;
#(
    parameter int                       C_ADDR_WIDTH       = 4,
    parameter int                       C_DATA_WIDTH       = 14,
    parameter logic [C_ADDR_WIDTH-1:0]  ADDR_UART_BOUDRATE = CM_ADDR_UART_BOUDRATE,
    parameter logic [C_ADDR_WIDTH-1:0]  ADDR_UART_PARITY   = CM_ADDR_UART_PARITY,
    parameter logic [C_ADDR_WIDTH-1:0]  ADDR_UART_STOP     = CM_ADDR_UART_STOP,
    parameter logic [C_ADDR_WIDTH-1:0]  ADDR_VGA_CONFIG    = CM_ADDR_VGA_CONFIG,
    parameter logic [C_ADDR_WIDTH-1:0]  ADDR_VGA_QUADRAN   = CM_ADDR_VGA_QUADRAN,
    parameter logic [C_ADDR_WIDTH-1:0]  ADDR_VGA_COLOR     = CM_ADDR_VGA_COLOR,
    parameter logic [BAUD_W-1:0]        RST_BAUD           = CM_RST_BAUD,
    parameter logic [PARITY_W-1:0]      RST_PARITY         = CM_RST_PARITY,
    parameter logic [RES_W-1:0]         RST_RES            = CM_RST_RES
) (
    input  logic                    Clk,
    input  logic                    Rst,
    input  logic [C_ADDR_WIDTH-1:0] C_Addr,
    input  logic [C_DATA_WIDTH-1:0] C_Data,
    input  logic                    C_Valid,
    output logic                    C_Rdy,
    input  logic                    UART_Busy,
    input  logic                    VGA_Frame_End,
    output logic [BAUD_W-1:0]       Baud_Sel,
    output logic [PARITY_W-1:0]     Parity_Sel,
    output logic [STOP_W-1:0]       Stop_Sel,
    output logic [RES_W-1:0]        Res_Sel,
    output logic [QUAD_W-1:0]       Quadran_Sel,
    output logic [C_DATA_WIDTH-1:0] Color,
    output logic                    Color_Valid,
    output logic                    Cfg_Applied,
    output logic                    Addr_Err,
    output logic                    Overrun
);

    localparam uart_cfg_t UART_RST = '{baud: RST_BAUD, parity: RST_PARITY, stop: '0};
    localparam vga_cfg_t  VGA_RST  = '{res: RST_RES, quad: '0};

    cm_state_t state_q, state_d;
    logic      c_rdy_q, c_rdy_d;
    logic      color_valid_q, color_valid_d;
    logic      cfg_applied_q, cfg_applied_d;
    logic      addr_err_q, addr_err_d;
    logic      overrun_q, overrun_d;

    logic [C_ADDR_WIDTH-1:0] addr_q;
    logic [C_DATA_WIDTH-1:0] data_q;
    logic [C_DATA_WIDTH-1:0] color_q, color_d;

    logic      uart_load, uart_commit, vga_load, vga_commit;
    uart_cfg_t uart_live, uart_new;
    vga_cfg_t  vga_live, vga_new;

`ifndef CM_CFG_FRAME_SYNC_EN
    logic unused_frame_end;
    assign unused_frame_end = VGA_Frame_End;
`endif

    // Holding registers carry data only; no reset needed.
    always_ff @(posedge Clk) begin
        if (state_q == ST_IDLE && C_Valid) begin
            addr_q <= C_Addr;
            data_q <= C_Data;
        end
    end

    always_comb begin
        state_d       = state_q;
        uart_load     = 1'b0;
        uart_commit   = 1'b0;
        vga_load      = 1'b0;
        vga_commit    = 1'b0;
        color_d       = color_q;
        color_valid_d = 1'b0;
        cfg_applied_d = 1'b0;
        addr_err_d    = 1'b0;
        overrun_d     = C_Valid && !c_rdy_q;

        case (state_q)
            ST_IDLE: begin
                if (C_Valid) begin
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                state_d = ST_IDLE;
                case (addr_q)
                    ADDR_VGA_COLOR: begin
                        color_d       = data_q;
                        color_valid_d = 1'b1;
                    end
                    ADDR_UART_BOUDRATE, ADDR_UART_PARITY, ADDR_UART_STOP: begin
                        uart_load = 1'b1;
                        state_d   = ST_WAIT_UART;
                    end
                    ADDR_VGA_CONFIG, ADDR_VGA_QUADRAN: begin
                        vga_load = 1'b1;
`ifdef CM_CFG_FRAME_SYNC_EN
                        state_d  = ST_WAIT_VGA;
`else
                        vga_commit    = 1'b1;
                        cfg_applied_d = 1'b1;
`endif
                    end
                    default: begin
                        addr_err_d = 1'b1;
                    end
                endcase
            end
            ST_WAIT_UART: begin
                if (!UART_Busy) begin
                    uart_commit   = 1'b1;
                    cfg_applied_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
`ifdef CM_CFG_FRAME_SYNC_EN
            ST_WAIT_VGA: begin
                if (VGA_Frame_End) begin
                    vga_commit    = 1'b1;
                    cfg_applied_d = 1'b1;
                    state_d       = ST_IDLE;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        c_rdy_d = (state_d == ST_IDLE);
    end

    // New shadow value: live group with only the addressed field replaced.
    always_comb begin
        uart_new = uart_live;
        vga_new  = vga_live;
        case (addr_q)
            ADDR_UART_BOUDRATE: uart_new.baud   = data_q[BAUD_W-1:0];
            ADDR_UART_PARITY:   uart_new.parity = data_q[PARITY_W-1:0];
            ADDR_UART_STOP:     uart_new.stop   = data_q[STOP_W-1:0];
            ADDR_VGA_CONFIG:    vga_new.res     = data_q[RES_W-1:0];
            ADDR_VGA_QUADRAN:   vga_new.quad    = data_q[QUAD_W-1:0];
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q       <= ST_IDLE;
            c_rdy_q       <= 1'b1;
            color_q       <= '0;
            color_valid_q <= 1'b0;
            cfg_applied_q <= 1'b0;
            addr_err_q    <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            c_rdy_q       <= c_rdy_d;
            color_q       <= color_d;
            color_valid_q <= color_valid_d;
            cfg_applied_q <= cfg_applied_d;
            addr_err_q    <= addr_err_d;
            overrun_q     <= overrun_d;
        end
    end

    color_manager_cfg_shadow #(
        .W       (UART_CFG_W),
        .RST_VAL (UART_RST)
    ) u_uart_shadow (
        .clk_i       (Clk),
        .rst_i       (Rst),
        .load_i      (uart_load),
        .load_data_i (uart_new),
        .commit_i    (uart_commit),
        .live_o      (uart_live)
    );

    color_manager_cfg_shadow #(
        .W       (VGA_CFG_W),
        .RST_VAL (VGA_RST)
    ) u_vga_shadow (
        .clk_i       (Clk),
        .rst_i       (Rst),
        .load_i      (vga_load),
        .load_data_i (vga_new),
        .commit_i    (vga_commit),
        .live_o      (vga_live)
    );

    assign C_Rdy       = c_rdy_q;
    assign Baud_Sel    = uart_live.baud;
    assign Parity_Sel  = uart_live.parity;
    assign Stop_Sel    = uart_live.stop;
    assign Res_Sel     = vga_live.res;
    assign Quadran_Sel = vga_live.quad;
    assign Color       = color_q;
    assign Color_Valid = color_valid_q;
    assign Cfg_Applied = cfg_applied_q;
    assign Addr_Err    = addr_err_q;
    assign Overrun     = overrun_q;

endmodule

// File: tb/tb_color_manager_config_responder.sv
// Directed self-checking bench for color_manager_config_responder.
module tb_color_manager_config_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  c_addr;
    logic [13:0] c_data;
    logic        c_valid;
    logic        c_rdy;
    logic        uart_busy;
    logic        frame_end;
    logic [2:0]  baud;
    logic [1:0]  parity;
    logic [0:0]  stop;
    logic [1:0]  res;
    logic [1:0]  quad;
    logic [13:0] color;
    logic        color_valid;
    logic        cfg_applied;
    logic        addr_err;
    logic        overrun;

    int checks   = 0;
    int failures = 0;

    color_manager_config_responder dut (
        .Clk           (clk),
        .Rst           (rst),
        .C_Addr        (c_addr),
        .C_Data        (c_data),
        .C_Valid       (c_valid),
        .C_Rdy         (c_rdy),
        .UART_Busy     (uart_busy),
        .VGA_Frame_End (frame_end),
        .Baud_Sel      (baud),
        .Parity_Sel    (parity),
        .Stop_Sel      (stop),
        .Res_Sel       (res),
        .Quadran_Sel   (quad),
        .Color         (color),
        .Color_Valid   (color_valid),
        .Cfg_Applied   (cfg_applied),
        .Addr_Err      (addr_err),
        .Overrun       (overrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one transaction for a single cycle, return just after it is sampled.
    task automatic send(input logic [3:0] a, input logic [13:0] d);
        c_addr  = a;
        c_data  = d;
        c_valid = 1'b1;
        step();
        c_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; c_addr = '0; c_data = '0; c_valid = 1'b0;
        uart_busy = 1'b0; frame_end = 1'b0;
        step(); step();
        rst = 1'b0;
        step();
        checks++; if (baud !== 3'd2) begin failures++; $display("FAIL reset_baud got=%0d exp=2", baud); end
        checks++; if (parity !== 2'd0) begin failures++; $display("FAIL reset_parity got=%0d exp=0", parity); end
        checks++; if (res !== 2'd0 || quad !== 2'd0 || stop !== 1'b0) begin failures++; $display("FAIL reset_vga_stop got=%0d/%0d/%0d exp=0/0/0", res, quad, stop); end
        checks++; if (c_rdy !== 1'b1) begin failures++; $display("FAIL reset_rdy got=%0b exp=1", c_rdy); end
        checks++; if (color !== 14'h0 || {color_valid, cfg_applied, addr_err, overrun} !== 4'b0) begin failures++; $display("FAIL reset_pulses got=%0h/%b exp=0/0000", color, {color_valid, cfg_applied, addr_err, overrun}); end
    endtask

    task automatic test_color();
        send(4'h0, 14'h0ABC);
        checks++; if (c_rdy !== 1'b0) begin failures++; $display("FAIL color_rdy_low got=%0b exp=0", c_rdy); end
        checks++; if (color_valid !== 1'b0 || color !== 14'h0) begin failures++; $display("FAIL color_early got=%0h/%0b exp=0/0", color, color_valid); end
        step();
        checks++; if (color !== 14'h0ABC) begin failures++; $display("FAIL color_value got=%0h exp=abc", color); end
        checks++; if (color_valid !== 1'b1 || c_rdy !== 1'b1) begin failures++; $display("FAIL color_valid_rdy got=%0b/%0b exp=1/1", color_valid, c_rdy); end
        step();
        checks++; if (color_valid !== 1'b0) begin failures++; $display("FAIL color_valid_pulse got=%0b exp=0", color_valid); end
    endtask

    task automatic test_back_to_back();
        send(4'h0, 14'h1555);
        step();
        send(4'h0, 14'h2AAA);
        checks++; if (color !== 14'h1555) begin failures++; $display("FAIL b2b_first got=%0h exp=1555", color); end
        step();
        checks++; if (color !== 14'h2AAA || color_valid !== 1'b1) begin failures++; $display("FAIL b2b_second got=%0h/%0b exp=2aaa/1", color, color_valid); end
        step();
    endtask

    task automatic test_uart_busy();
        uart_busy = 1'b1;
        send(4'h8, 14'h0004);
        for (int i = 0; i < 8; i++) step();
        checks++; if (baud !== 3'd2 || c_rdy !== 1'b0) begin failures++; $display("FAIL uart_hold got=%0d/%0b exp=2/0", baud, c_rdy); end
        uart_busy = 1'b0;
        step();
        checks++; if (baud !== 3'd4 || cfg_applied !== 1'b1) begin failures++; $display("FAIL uart_commit got=%0d/%0b exp=4/1", baud, cfg_applied); end
        checks++; if (c_rdy !== 1'b1) begin failures++; $display("FAIL uart_rdy got=%0b exp=1", c_rdy); end
        step();
        checks++; if (cfg_applied !== 1'b0) begin failures++; $display("FAIL uart_applied_pulse got=%0b exp=0", cfg_applied); end
    endtask

    task automatic test_uart_idle();
        // Upper data bits must be ignored: 0x3FFE -> parity 2, 0x0003 -> stop 1.
        send(4'h9, 14'h3FFE);
        step();
        checks++; if (parity !== 2'd0) begin failures++; $display("FAIL parity_early got=%0d exp=0", parity); end
        step();
        checks++; if (parity !== 2'd2 || cfg_applied !== 1'b1 || baud !== 3'd4) begin failures++; $display("FAIL parity_commit got=%0d/%0b/%0d exp=2/1/4", parity, cfg_applied, baud); end
        send(4'hA, 14'h0003);
        step(); step();
        checks++; if (stop !== 1'b1 || parity !== 2'd2) begin failures++; $display("FAIL stop_commit got=%0d/%0d exp=1/2", stop, parity); end
    endtask

    task automatic test_vga();
        send(4'hB, 14'h0001);
        step();
`ifdef CM_CFG_FRAME_SYNC_EN
        checks++; if (res !== 2'd0 || c_rdy !== 1'b0) begin failures++; $display("FAIL vga_wait got=%0d/%0b exp=0/0", res, c_rdy); end
        step(); step();
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
`endif
        checks++; if (res !== 2'd1 || cfg_applied !== 1'b1) begin failures++; $display("FAIL vga_res_commit got=%0d/%0b exp=1/1", res, cfg_applied); end
        checks++; if (c_rdy !== 1'b1) begin failures++; $display("FAIL vga_rdy got=%0b exp=1", c_rdy); end
        send(4'hC, 14'h3FF3);
`ifdef CM_CFG_FRAME_SYNC_EN
        // Frame end during DECODE must not trigger the commit.
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        step();
        checks++; if (quad !== 2'd0) begin failures++; $display("FAIL vga_early_frame got=%0d exp=0", quad); end
        frame_end = 1'b1;
`endif
        step();
        frame_end = 1'b0;
        checks++; if (quad !== 2'd3 || res !== 2'd1) begin failures++; $display("FAIL vga_quad_commit got=%0d/%0d exp=3/1", quad, res); end
    endtask

    task automatic test_addr_err();
        send(4'hF, 14'h3FFF);
        checks++; if (c_rdy !== 1'b0) begin failures++; $display("FAIL aerr_rdy_low got=%0b exp=0", c_rdy); end
        step();
        checks++; if (addr_err !== 1'b1 || c_rdy !== 1'b1) begin failures++; $display("FAIL aerr_pulse got=%0b/%0b exp=1/1", addr_err, c_rdy); end
        checks++; if ({baud, parity, stop, res, quad} !== {3'd4, 2'd2, 1'b1, 2'd1, 2'd3} || color !== 14'h2AAA) begin failures++; $display("FAIL aerr_regs_changed got=%0h/%0h exp=%0h/2aaa", {baud, parity, stop, res, quad}, color, {3'd4, 2'd2, 1'b1, 2'd1, 2'd3}); end
        step();
        checks++; if (addr_err !== 1'b0 || cfg_applied !== 1'b0) begin failures++; $display("FAIL aerr_once got=%0b/%0b exp=0/0", addr_err, cfg_applied); end
    endtask

    task automatic test_overrun();
        uart_busy = 1'b1;
        send(4'h8, 14'h0006);
        step(); step();
        send(4'h8, 14'h0001);
        checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL overrun_pulse got=%0b exp=1", overrun); end
        step();
        checks++; if (overrun !== 1'b0 || c_rdy !== 1'b0) begin failures++; $display("FAIL overrun_clear got=%0b/%0b exp=0/0", overrun, c_rdy); end
        uart_busy = 1'b0;
        step();
        checks++; if (baud !== 3'd6 || cfg_applied !== 1'b1) begin failures++; $display("FAIL overrun_commit got=%0d/%0b exp=6/1", baud, cfg_applied); end
        step(); step();
        checks++; if (baud !== 3'd6 || c_rdy !== 1'b1) begin failures++; $display("FAIL overrun_no_replay got=%0d/%0b exp=6/1", baud, c_rdy); end
    endtask

    task automatic test_reset_mid_wait();
        uart_busy = 1'b1;
        send(4'h8, 14'h0005);
        step(); step();
        #2 rst = 1'b1;
        #1;
        checks++; if (baud !== 3'd2 || c_rdy !== 1'b1 || color !== 14'h0) begin failures++; $display("FAIL rst_uart_async got=%0d/%0b/%0h exp=2/1/0", baud, c_rdy, color); end
        step();
        rst = 1'b0;
        uart_busy = 1'b0;
        step(); step(); step();
        checks++; if (baud !== 3'd2 || cfg_applied !== 1'b0) begin failures++; $display("FAIL rst_uart_discard got=%0d/%0b exp=2/0", baud, cfg_applied); end
`ifdef CM_CFG_FRAME_SYNC_EN
        send(4'hB, 14'h0002);
        step(); step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (res !== 2'd0 || c_rdy !== 1'b1) begin failures++; $display("FAIL rst_vga_state got=%0d/%0b exp=0/1", res, c_rdy); end
        frame_end = 1'b1;
        step();
        frame_end = 1'b0;
        step();
        checks++; if (res !== 2'd0 || cfg_applied !== 1'b0) begin failures++; $display("FAIL rst_vga_discard got=%0d/%0b exp=0/0", res, cfg_applied); end
`endif
    endtask

    initial begin
        test_reset();
        test_color();
        test_back_to_back();
        test_uart_busy();
        test_uart_idle();
        test_vga();
        test_addr_err();
        test_overrun();
        test_reset_mid_wait();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
